// File: rtl/aligner_pkg.sv
// ============================================================================
// Module  : aligner_pkg
// Brief   : Shared channel enumeration and helpers for the operand aligner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aligner_pkg;

  localparam int CH_NUM = 4;

  // Enum value doubles as the bit index into overflow_o and the ready vector.
  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

  function automatic logic all_ready(input logic [CH_NUM-1:0] not_empty);
    return &not_empty;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ch_fifo.sv
// ============================================================================
// Module  : ch_fifo
// Brief   : Single-channel operand FIFO with registered count, comb head read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         artsn_i,
  input  logic                         wr_en_i,
  input  logic                         rd_en_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard locally so a misbehaving parent can never corrupt the pointers.
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_aligner.sv
// ============================================================================
// Module  : operand_aligner
// Brief   : Buffers four independently strobed operands and issues aligned
//           {a,b,c,d} tuples with a single valid pulse per tuple.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_aligner
  import aligner_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  artsn_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic                  a_valid_i,
  input  logic                  b_valid_i,
  input  logic                  c_valid_i,
  input  logic                  d_valid_i,
  output logic                  a_ready_o,
  output logic                  b_ready_o,
  output logic                  c_ready_o,
  output logic                  d_ready_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [DATA_WIDTH-1:0] c_o,
  output logic [DATA_WIDTH-1:0] d_o,
  output logic                  valid_o,
  output logic [CH_NUM-1:0]     overflow_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CH_NUM-1:0]     valid_in;
  logic [CH_NUM-1:0]     wr_en;
  logic [CH_NUM-1:0]     full;
  logic [CH_NUM-1:0]     empty;
  logic [DATA_WIDTH-1:0] wdata [CH_NUM];
  logic [DATA_WIDTH-1:0] rdata [CH_NUM];
  logic [CNT_W-1:0]      count [CH_NUM];
  logic                  pop;

  logic [DATA_WIDTH-1:0] tuple_q [CH_NUM];
  logic [DATA_WIDTH-1:0] tuple_d [CH_NUM];
  logic                  valid_q, valid_d;
  logic [CH_NUM-1:0]     overflow_q, overflow_d;

  assign valid_in = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};

  assign wdata[CH_A] = a_i;
  assign wdata[CH_B] = b_i;
  assign wdata[CH_C] = c_i;
  assign wdata[CH_D] = d_i;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    ch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .artsn_i (artsn_i),
      .wr_en_i (wr_en[g]),
      .rd_en_i (pop),
      .wdata_i (wdata[g]),
      .rdata_o (rdata[g]),
      .count_o (count[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );

    a_full_tracks_count: assert property (
      @(posedge clk_i) disable iff (!artsn_i)
      (full[g] == (count[g] == CNT_W'(DEPTH))) && (empty[g] == (count[g] == '0))
    );
  end

  // Ready and pop look only at registered occupancy, so neither feeds back
  // combinationally from the consumer side or from the same-cycle pop.
  assign wr_en = valid_in & ~full;
  assign pop   = all_ready(~empty);

  assign a_ready_o = ~full[CH_A];
  assign b_ready_o = ~full[CH_B];
  assign c_ready_o = ~full[CH_C];
  assign d_ready_o = ~full[CH_D];

  always_comb begin
    valid_d    = pop;
    overflow_d = overflow_q | (valid_in & full);
    tuple_d    = tuple_q;
    if (pop) begin
      tuple_d = rdata;
    end
  end

  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      for (int i = 0; i < CH_NUM; i++) begin
        tuple_q[i] <= '0;
      end
      valid_q    <= 1'b0;
      overflow_q <= '0;
    end else begin
      tuple_q    <= tuple_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign a_o        = tuple_q[CH_A];
  assign b_o        = tuple_q[CH_B];
  assign c_o        = tuple_q[CH_C];
  assign d_o        = tuple_q[CH_D];
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_aligner.sv
// ============================================================================
// Module  : tb_operand_aligner
// Brief   : Randomised self-checking bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_aligner;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          artsn_i = 1'b0;
  logic [DW-1:0] din [4];
  logic [3:0]    vin = 4'b0;

  logic [DW-1:0] a_o, b_o, c_o, d_o;
  logic          a_ready_o, b_ready_o, c_ready_o, d_ready_o;
  logic          valid_o;
  logic [3:0]    overflow_o;

  // Reference state: one queue per channel holding accepted operands.
  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] exp_t [4];
  logic          exp_valid;
  logic [3:0]    ovf_m;
  int            n_tuples;
  int            n_chk;
  int            n_fail;

  always #5 clk = ~clk;

  operand_aligner #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .artsn_i    (artsn_i),
    .a_i        (din[0]),
    .b_i        (din[1]),
    .c_i        (din[2]),
    .d_i        (din[3]),
    .a_valid_i  (vin[0]),
    .b_valid_i  (vin[1]),
    .c_valid_i  (vin[2]),
    .d_valid_i  (vin[3]),
    .a_ready_o  (a_ready_o),
    .b_ready_o  (b_ready_o),
    .c_ready_o  (c_ready_o),
    .d_ready_o  (d_ready_o),
    .a_o        (a_o),
    .b_o        (b_o),
    .c_o        (c_o),
    .d_o        (d_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream core result, used to cross-check the aligned tuple.
  function automatic longint core_q(input logic [DW-1:0] a, b, c, d);
    return ((longint'(a) - longint'(b)) * (64'sd1 + 64'sd3 * longint'(c)) - 64'sd4 * longint'(d)) / 2;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      exp_t[c] = '0;
    end
    exp_valid = 1'b0;
    ovf_m     = '0;
  endtask

  task automatic check_outputs(input string phase);
    logic [3:0] rdy_m;
    for (int c = 0; c < 4; c++) rdy_m[c] = (mq[c].size() != DEPTH);
    chk({phase, ".valid"}, 64'(valid_o), 64'(exp_valid));
    chk({phase, ".ready"}, 64'({d_ready_o, c_ready_o, b_ready_o, a_ready_o}), 64'(rdy_m));
    chk({phase, ".overflow"}, 64'(overflow_o), 64'(ovf_m));
    chk({phase, ".a_o"}, 64'(a_o), 64'(exp_t[0]));
    chk({phase, ".b_o"}, 64'(b_o), 64'(exp_t[1]));
    chk({phase, ".c_o"}, 64'(c_o), 64'(exp_t[2]));
    chk({phase, ".d_o"}, 64'(d_o), 64'(exp_t[3]));
    if (exp_valid) begin
      chk({phase, ".q"}, 64'(core_q(a_o, b_o, c_o, d_o)),
          64'(core_q(exp_t[0], exp_t[1], exp_t[2], exp_t[3])));
    end
  endtask

  // One clock: decide acceptance/pop from pre-edge occupancy, update model, check.
  task automatic cycle(input string phase);
    logic [3:0] acc;
    logic       pop;
    pop = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (mq[c].size() == 0) pop = 1'b0;
      acc[c] = vin[c] && (mq[c].size() < DEPTH);
      if (vin[c] && !acc[c]) ovf_m[c] = 1'b1;
    end
    @(posedge clk);
    exp_valid = pop;
    if (pop) begin
      for (int c = 0; c < 4; c++) exp_t[c] = mq[c].pop_front();
      n_tuples++;
    end
    for (int c = 0; c < 4; c++) if (acc[c]) mq[c].push_back(din[c]);
    #1;
    check_outputs(phase);
    vin = 4'b0;
  endtask

  task automatic put(input logic [3:0] v, input logic [DW-1:0] a, b, c, d, input string phase);
    vin    = v;
    din[0] = a;
    din[1] = b;
    din[2] = c;
    din[3] = d;
    cycle(phase);
  endtask

  task automatic idle(input int n, input string phase);
    for (int i = 0; i < n; i++) cycle(phase);
  endtask

  task automatic check_reset_state(input string phase);
    chk({phase, ".valid"}, 64'(valid_o), 64'd0);
    chk({phase, ".ready"}, 64'({d_ready_o, c_ready_o, b_ready_o, a_ready_o}), 64'hF);
    chk({phase, ".overflow"}, 64'(overflow_o), 64'd0);
    chk({phase, ".tuple"}, 64'(a_o | b_o | c_o | d_o), 64'd0);
  endtask

  initial begin
    int start;
    int iters;
    n_chk    = 0;
    n_fail   = 0;
    n_tuples = 0;
    for (int c = 0; c < 4; c++) din[c] = '0;
    model_clear();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    #3 artsn_i = 1'b1;
    idle(2, "post_por");

    // Staggered arrival: a@t0, c@t2, b@t5, d@t7 -> tuple at t8
    put(4'b0001, 32'd10, 0, 0, 0, "stagger");
    idle(1, "stagger");
    put(4'b0100, 0, 0, 32'd3, 0, "stagger");
    idle(2, "stagger");
    put(4'b0010, 0, 32'd4, 0, 0, "stagger");
    idle(1, "stagger");
    put(4'b1000, 0, 0, 0, 32'd1, "stagger");
    chk("stagger.no_early_valid", 64'(valid_o), 64'd0);
    idle(1, "stagger");
    chk("stagger.pulse", 64'(valid_o), 64'd1);
    chk("stagger.core_q", 64'(core_q(a_o, b_o, c_o, d_o)), 64'd28);
    idle(1, "stagger");
    chk("stagger.single_pulse", 64'(valid_o), 64'd0);

    // Burst: all channels every cycle
    for (int i = 0; i < 4; i++) put(4'b1111, i, i + 1, i + 2, i + 3, "burst");
    idle(5, "burst");

    // Skew to full on a, then a dropped 5th write, then b/c/d catch up
    for (int i = 0; i < 5; i++) put(4'b0001, 32'h100 + i, 0, 0, 0, "skew");
    chk("skew.overflow_a", 64'(overflow_o), 64'h1);
    for (int i = 0; i < 4; i++) put(4'b1110, 0, 32'h200 + i, 32'h300 + i, 32'h400 + i, "skew");
    idle(3, "skew");

    // Simultaneous write and pop on a channel holding one entry
    put(4'b1111, 32'd100, 32'd101, 32'd102, 32'd103, "simul");
    put(4'b1111, 32'd200, 32'd201, 32'd202, 32'd203, "simul");
    idle(3, "simul");

    // Reset mid-traffic: partially buffered operands must vanish
    put(4'b0011, 32'hAA, 32'hBB, 0, 0, "pre_rst");
    put(4'b0100, 0, 0, 32'hCC, 0, "pre_rst");
    #3 artsn_i = 1'b0;
    #1;
    check_reset_state("mid_rst");
    #99;
    check_reset_state("mid_rst_hold");
    artsn_i = 1'b1;
    model_clear();
    idle(3, "post_rst");
    put(4'b0111, 32'h11, 32'h22, 32'h33, 0, "post_rst");
    idle(2, "post_rst");
    put(4'b1000, 0, 0, 0, 32'h44, "post_rst");
    idle(2, "post_rst");

    // Random traffic long enough to wrap the pointers several times
    start = n_tuples;
    iters = 0;
    while ((n_tuples - start) < (3 * DEPTH + 1) && iters < 2000) begin
      for (int c = 0; c < 4; c++) begin
        vin[c] = ($urandom_range(0, 99) < 45);
        din[c] = $urandom;
      end
      cycle("random");
      iters++;
    end
    chk("random.enough_tuples", 64'((n_tuples - start) >= (3 * DEPTH + 1)), 64'd1);
    idle(2 * DEPTH, "random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
